// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter (package arb_pkg).
// The winner search rotates the request vector so that ptr lands at bit 0.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Bit j of the rotated vector is req[(ptr + j) mod 8]; the lowest set bit
  // is the closest requester in wrap order, so adding ptr back gives its index.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
    return ptr + off;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
  import arb_pkg::*;

  // Handshake: req[i] is a level held by requester i until it is done; the
  // grant appears one clock after req is sampled and is kept for as long as
  // req[gnt_idx] stays high. Dropping req[gnt_idx] releases the resource on
  // the next edge and a one-cycle all-zero gap always follows a grant.
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_arbiter_8_grant_decode.sv
// grant_decode_3_8: 3-bit index to 8-bit one-hot; en low forces all-zero.
module grant_decode_3_8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter, 8 requesters, registered one-hot grant with a gap cycle.
// Optional forced release after HOLD_MAX grant cycles under `ARB_TIMEOUT_EN.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  rr_arbiter_8_if.slave bus,
  output arb_state_e state_o
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("rr_arbiter_8: HOLD_MAX must be in 1..255");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|bus.req) begin
          state_d = ARB_GRANT;
          idx_d   = rr_pick(bus.req, ptr_q);
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        // Only the holder's request matters here; others wait for the gap.
        if (!bus.req[idx_q]) begin
          state_d = ARB_IDLE;
          valid_d = 1'b0;
          ptr_d   = idx_q + 3'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          state_d   = ARB_IDLE;
          valid_d   = 1'b0;
          ptr_d     = idx_q + 3'd1;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = ARB_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Decode the next index so the one-hot grant itself comes straight from a flop.
  grant_decode_3_8 u_decode (
    .idx_i    (idx_d),
    .en_i     (valid_d),
    .onehot_o (gnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus random requests
// compared every cycle against a wrap-order reference model.
module tb_rr_arbiter_8;
  import arb_pkg::*;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  arb_state_e state;
  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: whoever holds the resource, where the search starts,
  // and how many cycles the current grant has lasted
  int m_ptr    = 0;
  int m_idx    = 0;
  int m_cycles = 0;
  bit m_busy   = 1'b0;
  bit m_to     = 1'b0;

  task automatic model_reset();
    m_ptr = 0; m_idx = 0; m_cycles = 0; m_busy = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    m_to = 1'b0;
    if (!m_busy) begin
      if (r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (r[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            break;
          end
        end
        m_busy   = 1'b1;
        m_cycles = 0;
      end
    end else begin
      m_cycles++;
      if (!r[m_idx]) begin
        m_busy = 1'b0;
        m_ptr  = (m_idx + 1) % 8;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_cycles == HOLD) begin
        m_busy = 1'b0;
        m_ptr  = (m_idx + 1) % 8;
        m_to   = 1'b1;
      end
`endif
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step(bus.req);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_outputs();
    check("gnt", 32'(bus.gnt), m_busy ? (32'd1 << m_idx) : 32'd0);
    check("gnt_valid", 32'(bus.gnt_valid), 32'(m_busy));
    if (m_busy) check("gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
    check("timeout", 32'(bus.timeout), 32'(m_to));
    check("state", 32'(state), m_busy ? 32'd1 : 32'd0);
  endtask

  // driver: check the settled outputs at the falling edge, then apply req
  task automatic step_req(input logic [7:0] r);
    @(negedge clk);
    cmp_outputs();
    bus.req = r;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.req = 8'h00;
    @(negedge clk);
    cmp_outputs();
    rst = 1'b0;
  endtask

  initial begin
    int         n_gr;
    int         held;
    logic [7:0] r;

    bus.req = 8'h00;
    repeat (2) @(negedge clk);
    cmp_outputs();
    check("rst_idx", 32'(bus.gnt_idx), 32'd0);
    rst = 1'b0;

    // single request, 1-cycle latency, release on drop
    step_req(8'h10);
    step_req(8'h10);
    check("single_gnt", 32'(bus.gnt), 32'h10);
    check("single_idx", 32'(bus.gnt_idx), 32'd4);
    repeat (3) step_req(8'h10);
    step_req(8'h00);
    step_req(8'h00);
    check("single_release", 32'(bus.gnt), 32'h00);

    // wrap: release idx 6 so ptr=7, then 0 beats 6
    step_req(8'h40);
    step_req(8'h40);
    check("wrap_first", 32'(bus.gnt), 32'h40);
    step_req(8'h00);
    step_req(8'h41);
    step_req(8'h41);
    check("wrap_gnt", 32'(bus.gnt), 32'h01);
    step_req(8'h00);
    step_req(8'h00);

    // no preemption: idx 3 keeps the grant while req[1] waits
    step_req(8'h08);
    step_req(8'h0A);
    check("nopre_hold0", 32'(bus.gnt), 32'h08);
    for (int i = 0; i < 3; i++) begin
      step_req(8'h0A);
      check("nopre_hold", 32'(bus.gnt), 32'h08);
    end
    step_req(8'h02);
    step_req(8'h02);
    check("nopre_gap", 32'(bus.gnt), 32'h00);
    step_req(8'h02);
    check("nopre_next", 32'(bus.gnt), 32'h02);
    step_req(8'h00);
    step_req(8'h00);

    // async reset in the middle of a grant
    step_req(8'h04);
    step_req(8'h04);
    check("rstmid_before", 32'(bus.gnt), 32'h04);
    #2 rst = 1'b1;
    #1;
    check("rstmid_gnt", 32'(bus.gnt), 32'h00);
    check("rstmid_valid", 32'(bus.gnt_valid), 32'd0);
    @(negedge clk);
    cmp_outputs();
    rst = 1'b0;
    bus.req = 8'h81;
    step_req(8'h00);
    check("rstmid_first", 32'(bus.gnt), 32'h01);
    step_req(8'h00);

    // hold limit (or indefinite hold without the timeout feature)
    reset_dut();
    step_req(8'h03);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < HOLD; i++) begin
      step_req(8'h03);
      check("to_hold", 32'(bus.gnt), 32'h01);
    end
    step_req(8'h03);
    check("to_gap", 32'(bus.gnt), 32'h00);
    check("to_pulse", 32'(bus.timeout), 32'd1);
    step_req(8'h03);
    check("to_next", 32'(bus.gnt), 32'h02);
`else
    for (int i = 0; i < 10; i++) begin
      step_req(8'h03);
      check("hold_forever", 32'(bus.gnt), 32'h01);
      check("no_timeout", 32'(bus.timeout), 32'd0);
    end
`endif
    step_req(8'h00);
    step_req(8'h00);

    // rotation: all requesting, each grantee drops for one cycle
    reset_dut();
    bus.req = 8'hFF;
    n_gr = 0;
    held = 0;
    for (int c = 0; c < 80 && n_gr < 9; c++) begin
      @(negedge clk);
      cmp_outputs();
      if (m_busy) begin
        held++;
        if (held == 1) begin
          check("rot_order", 32'(bus.gnt_idx), 32'(n_gr % 8));
          n_gr++;
        end
        r = 8'hFF;
        if (held == 2) r[m_idx] = 1'b0;
        bus.req = r;
      end else begin
        held = 0;
        bus.req = 8'hFF;
      end
    end
    check("rot_count", 32'(n_gr), 32'd9);

    // random request traffic
    reset_dut();
    r = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      r = r ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 40) == 0) r = 8'h00;
      step_req(r);
    end
    step_req(8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
